vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter LOCK_LINES, default 2: consecutive well-formed lines required before vertical alignment.
REQ-002 SHALL have port clock, input, 1: 25 MHz pixel clock; one hsync/vsync sample per rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port hsync, input, 1: active-low horizontal sync, 640x480@60 timing.
REQ-005 SHALL have port vsync, input, 1: active-low vertical sync, same timing.
REQ-006 SHALL have port pixel_x, output, 10: recovered column of the most recent sample.
REQ-007 SHALL have port pixel_y, output, 10: recovered line of the most recent sample.
REQ-008 SHALL have port video_enable, output, 1: locked, pixel_x<640 and pixel_y<480.
REQ-009 SHALL have port frame_start, output, 1: one-cycle pulse when locked and (pixel_x,pixel_y)=(0,0).
REQ-010 SHALL have port locked, output, 1: high in state LOCKED only.
REQ-011 SHALL have ports h_err and v_err, output, 1 each: one-cycle timing-violation pulses.

Function
REQ-012 SHALL use horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799 (800 total).
REQ-013 SHALL use vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524 (525 total).
REQ-014 SHALL register the previous hsync/vsync samples; a falling edge is previous=1, current=0.
REQ-015 SHALL, on an hsync falling edge outside LOCKED, load h_cnt=656; otherwise h_cnt wraps 799->0, else increments.
REQ-016 SHALL increment v_cnt (wrap 524->0) on each h_cnt 799->0 wrap; on a vsync falling edge in V_ALIGN, set the current line to 490.
REQ-017 SHALL present pixel_x/pixel_y as the counters labelling the sample captured at the same clock edge (latency 1 cycle from input).
REQ-018 SHALL implement states UNLOCKED, H_ALIGN, V_ALIGN, LOCKED.
REQ-019 UNLOCKED -> H_ALIGN on the first hsync falling edge.
REQ-020 In H_ALIGN, a hsync falling edge with predicted column 656 increments a good-line counter, otherwise clears it; reaching LOCK_LINES -> V_ALIGN.
REQ-021 V_ALIGN -> LOCKED on a vsync falling edge; a misplaced hsync edge in V_ALIGN -> H_ALIGN.
REQ-022 In LOCKED, hsync SHALL be 0 exactly for columns 656-751; any mismatch pulses h_err and goes to H_ALIGN.
REQ-023 In LOCKED, vsync sampled at column 0 SHALL be 0 exactly on lines 490-491; mismatch pulses v_err and goes to V_ALIGN.
REQ-024 SHALL give h_err priority when both errors occur in one cycle; v_err not pulsed then.
REQ-025 video_enable and frame_start SHALL be 0 in every state except LOCKED.

Reset
REQ-026 SHALL, on reset, enter UNLOCKED, clear h_cnt, v_cnt, good-line counter and all outputs to 0, previous samples to 1.
REQ-027 SHALL abandon any alignment or lock on reset mid-frame with no error pulse.

Structure
REQ-028 SHALL take timing constants (H/V visible, porch, sync, total) and the state enum from shared package vga_timing_pkg, also used by VGA_sync.
REQ-029 SHALL instantiate sub-module sync_edge_detect twice (hsync, vsync); all else in one module.

Verification
REQ-030 Reset, then drive VGA_sync output for 3 frames -> locked=1 by first vsync edge; frame_start pulses every 420000 cycles; pixel_x/pixel_y equal VGA_sync counters delayed 1 cycle.
REQ-031 Locked; extend one hsync pulse to 97 cycles -> h_err pulses once at column 752, locked=0, relocks by next vsync edge.
REQ-032 Locked; hold vsync high on line 490 -> v_err at (0,490), state V_ALIGN, video_enable=0 until relock.
REQ-033 Hsync edges 799 cycles apart in H_ALIGN -> good-line counter cleared, no V_ALIGN until 2 consecutive 800-cycle lines.
REQ-034 Assert reset at (320,240) while locked -> all outputs 0 immediately (asynchronous), no error pulse, normal relock after release.
REQ-035 Count video_enable over one locked frame -> exactly 307200 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, decoder state enum and window helper
package vga_timing_pkg;
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BACK = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END = H_SYNC_START + H_SYNC - 10'd1;
  localparam logic [9:0] H_TOTAL = H_SYNC_END + 10'd1 + H_BACK;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BACK = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END = V_SYNC_START + V_SYNC - 10'd1;
  localparam logic [9:0] V_TOTAL = V_SYNC_END + 10'd1 + V_BACK;
  typedef enum logic [1:0] {UNLOCKED, H_ALIGN, V_ALIGN, LOCKED} sync_state_t;
  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: falling-edge detector for an active-low sync (in: clock, reset, sync; out: fall = previous sample 1, current sample 0)
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sync,
  output logic fall
);
  logic prev;
  always_ff @(posedge clock or posedge reset)
    if (reset) prev <= 1'b1;
    else prev <= sync;
  assign fall = prev & ~sync;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers 640x480@60 coordinates and lock from hsync/vsync (in: clock, reset, hsync, vsync; out: pixel_x, pixel_y, video_enable, frame_start, locked, h_err, v_err)
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int LOCK_LINES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_enable,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);
  localparam int GW = $clog2(LOCK_LINES + 1);
  sync_state_t state, state_n;
  logic h_fall, v_fall, reload, h_wrap, h_bad, v_bad;
  logic [9:0] h_cnt, v_cnt, h_pred, h_n, v_n;
  logic [GW-1:0] good, good_n;
  sync_edge_detect u_h (.clock(clock), .reset(reset), .sync(hsync), .fall(h_fall));
  sync_edge_detect u_v (.clock(clock), .reset(reset), .sync(vsync), .fall(v_fall));
  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
  always_comb begin
    h_pred = h_cnt == H_TOTAL - 10'd1 ? '0 : h_cnt + 10'd1;
    reload = h_fall && state != LOCKED;
    h_wrap = !reload && h_cnt == H_TOTAL - 10'd1;
    h_n = reload ? H_SYNC_START : h_pred;
    v_n = v_fall && state == V_ALIGN ? V_SYNC_START :
          !h_wrap ? v_cnt : v_cnt == V_TOTAL - 10'd1 ? '0 : v_cnt + 10'd1;
    // sync is active-low, so a level equal to the window flag is a mismatch
    h_bad = hsync == in_win(h_n, H_SYNC_START, H_SYNC_END);
    v_bad = h_n == '0 && vsync == in_win(v_n, V_SYNC_START, V_SYNC_END);
    state_n = state;
    good_n = good;
    case (state)
      UNLOCKED: state_n = h_fall ? H_ALIGN : UNLOCKED;
      H_ALIGN:
        if (h_fall) begin
          good_n = h_pred == H_SYNC_START ? good + GW'(1) : '0;
          if (good_n == GW'(LOCK_LINES)) begin
            state_n = V_ALIGN;
            good_n = '0;
          end
        end
      V_ALIGN: state_n = h_fall && h_pred != H_SYNC_START ? H_ALIGN : v_fall ? LOCKED : V_ALIGN;
      LOCKED: state_n = h_bad ? H_ALIGN : v_bad ? V_ALIGN : LOCKED;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= UNLOCKED;
      h_cnt <= '0;
      v_cnt <= '0;
      good <= '0;
      locked <= 1'b0;
      video_enable <= 1'b0;
      frame_start <= 1'b0;
      h_err <= 1'b0;
      v_err <= 1'b0;
    end else begin
      state <= state_n;
      h_cnt <= h_n;
      v_cnt <= v_n;
      good <= good_n;
      locked <= state_n == LOCKED;
      video_enable <= state_n == LOCKED && h_n < H_VISIBLE && v_n < V_VISIBLE;
      frame_start <= state_n == LOCKED && h_n == '0 && v_n == '0;
      h_err <= state == LOCKED && h_bad;
      v_err <= state == LOCKED && !h_bad && v_bad;
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed VGA line sequences with per-cycle expected lock/coordinate/error values
module tb_vga_sync_decoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hsync = 1'b1;
  logic vsync = 1'b1;
  logic [9:0] pixel_x, pixel_y;
  logic video_enable, frame_start, locked, h_err, v_err;
  int n_chk = 0;
  int n_fail = 0;
  int ve_cnt;
  bit lk = 1'b0;
  vga_sync_decoder #(.LOCK_LINES(2)) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_enable(video_enable),
    .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_pixel_x"}, pixel_x, 0);
    check({tag, "_pixel_y"}, pixel_y, 0);
    check({tag, "_video_enable"}, video_enable, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_h_err"}, h_err, 0);
    check({tag, "_v_err"}, v_err, 0);
  endtask
  // one line of generated timing; lk changes at lock_at/unlock_at, error pulses expected at herr/verr
  task automatic line(input int y, input int len, input int hs_w, input bit hs0, input int vmode,
                      input int herr, input int verr, input int lock_at, input int unlock_at);
    ve_cnt = 0;
    for (int x = 0; x < len; x++) begin
      hsync = !((x >= 656 && x < 656 + hs_w) || (hs0 && x == 0));
      vsync = vmode == 1 ? 1'b1 : vmode == 2 ? 1'b0 : !(y == 490 || y == 491);
      if (x == lock_at) lk = 1'b1;
      if (x == unlock_at) lk = 1'b0;
      @(posedge clock);
      #1;
      check("locked", locked, lk);
      check("h_err", h_err, x == herr);
      check("v_err", v_err, x == verr);
      check("video_enable", video_enable, lk && x < 640 && y < 480);
      check("frame_start", frame_start, lk && x == 0 && y == 0);
      if (lk) begin
        check("pixel_x", pixel_x, x);
        check("pixel_y", pixel_y, y);
      end
      ve_cnt += video_enable;
    end
  endtask
  task automatic norm(input int y);
    line(y, 800, 96, 1'b0, 0, -1, -1, -1, -1);
  endtask
  task automatic lock_line();
    line(490, 800, 96, 1'b0, 0, -1, -1, 0, -1);
  endtask
  task automatic apply_reset();
    hsync = 1'b1;
    vsync = 1'b1;
    reset = 1'b1;
    lk = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic acquire();
    for (int y = 487; y < 490; y++) norm(y);
    lock_line();
    norm(491);
  endtask
  initial begin
    apply_reset();
    check_zero("reset");
    // lock, run to the frame start, count a visible line, then reset asynchronously at (320,1)
    acquire();
    for (int y = 492; y < 525; y++) norm(y);
    norm(0);
    check("ve_line0", ve_cnt, 640);
    line(1, 321, 96, 1'b0, 0, -1, -1, -1, -1);
    check("ve_pre_reset", video_enable, 1);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    lk = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    // relock after reset, then a 97-cycle hsync pulse and relock on the next vsync edge
    acquire();
    line(492, 800, 97, 1'b0, 0, 752, -1, -1, 752);
    for (int y = 487; y < 490; y++) norm(y);
    lock_line();
    norm(491);
    // vsync held low past its pulse, then simultaneous h/v violation
    apply_reset();
    acquire();
    line(492, 800, 96, 1'b0, 2, -1, 0, -1, 0);
    norm(488);
    norm(489);
    lock_line();
    norm(491);
    line(492, 800, 96, 1'b1, 2, 0, -1, -1, 0);
    for (int y = 487; y < 490; y++) norm(y);
    lock_line();
    norm(491);
    // short line in H_ALIGN clears the good-line count so the first vsync edge is missed
    apply_reset();
    line(487, 799, 96, 1'b0, 0, -1, -1, -1, -1);
    norm(488);
    norm(489);
    norm(490);
    norm(491);
    norm(488);
    norm(489);
    lock_line();
    norm(491);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
